// File: rtl/data_bus_responder_pkg.sv
// Shared constants and types for the data-bus responder: I/O register map,
// UART status layout and the transmitter state encoding.
package data_bus_pkg;

    // Address bit that separates RAM (0) from the I/O block (1)
    localparam int IO_SEL_BIT = 22;

    // I/O registers, indexed by Address[4:2] (byte offset / 4 from 0x400000)
    localparam logic [2:0] IO_LEDS        = 3'd0;  // 0x00
    localparam logic [2:0] IO_UART_DATA   = 3'd1;  // 0x04
    localparam logic [2:0] IO_UART_STATUS = 3'd2;  // 0x08
    localparam logic [2:0] IO_CYCLES      = 3'd3;  // 0x0C
    localparam logic [2:0] IO_END         = 3'd4;  // 0x10

    // UART_STATUS bit layout
    localparam int STAT_FULL_BIT  = 0;
    localparam int STAT_BUSY_BIT  = 1;
    localparam int STAT_OVF_BIT   = 2;
    localparam int STAT_COUNT_LSB = 8;

    // Serial transmitter frame phases
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/data_bus_responder_uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 serial transmitter. Pushes into a full FIFO are
// dropped and latch a sticky overflow flag. The line output is registered.
module uart_tx_fifo
    import data_bus_pkg::*;
#(
    parameter int UART_DIV   = 16,
    parameter int FIFO_DEPTH = 8,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [7:0]       din,
    output logic             tx,
    output logic             full,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam int BIT_CNT_W = (UART_DIV > 1) ? $clog2(UART_DIV) : 1;

    logic [7:0]           r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_ovf;

    tx_state_e            r_state;
    tx_state_e            w_state_next;
    logic [BIT_CNT_W-1:0] r_bit_cnt;
    logic [BIT_CNT_W-1:0] w_bit_cnt_next;
    logic [2:0]           r_bit_idx;
    logic [2:0]           w_bit_idx_next;
    logic [7:0]           r_shift;
    logic                 r_tx;
    logic                 w_tx_next;

    logic                 w_push_ok;
    logic                 w_pop;
    logic                 w_bit_done;

    // Acceptance depends only on occupancy before the edge, never on a same-cycle pop
    assign w_push_ok  = push && (r_count < CNT_W'(FIFO_DEPTH));
    assign w_bit_done = (r_bit_cnt == BIT_CNT_W'(UART_DIV - 1));

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push_ok && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push_ok && w_pop) r_count <= r_count - 1'b1;
            if (push && !w_push_ok) r_ovf <= 1'b1;
        end
    end

    // FIFO storage and transmit shift register hold data only, so no reset
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= din;
        if (w_pop)     r_shift <= r_mem[r_rd_ptr];
    end

    // Transmitter state register; reset forces the line high immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= TX_IDLE;
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_tx      <= w_tx_next;
        end
    end

    // Next-state logic: each phase lasts UART_DIV cycles, DATA repeats for 8 bits
    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_bit_idx_next = r_bit_idx;
        w_pop          = 1'b0;
        case (r_state)
            TX_IDLE: begin
                if (r_count != '0) begin
                    w_pop          = 1'b1;
                    w_state_next   = TX_START;
                    w_bit_cnt_next = '0;
                end
            end
            TX_START: begin
                if (w_bit_done) begin
                    w_state_next   = TX_DATA;
                    w_bit_cnt_next = '0;
                    w_bit_idx_next = '0;
                end else begin
                    w_bit_cnt_next = r_bit_cnt + 1'b1;
                end
            end
            TX_DATA: begin
                if (w_bit_done) begin
                    w_bit_cnt_next = '0;
                    if (r_bit_idx == 3'd7) w_state_next = TX_STOP;
                    else                   w_bit_idx_next = r_bit_idx + 1'b1;
                end else begin
                    w_bit_cnt_next = r_bit_cnt + 1'b1;
                end
            end
            TX_STOP: begin
                if (w_bit_done) begin
                    w_state_next   = TX_IDLE;
                    w_bit_cnt_next = '0;
                end else begin
                    w_bit_cnt_next = r_bit_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next   = TX_IDLE;
                w_bit_cnt_next = '0;
            end
        endcase
    end

    // Line level for the coming cycle, registered so tx never glitches
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            TX_START: w_tx_next = 1'b0;
            TX_DATA:  w_tx_next = r_shift[w_bit_idx_next];
            default:  w_tx_next = 1'b1;
        endcase
    end

    assign tx       = r_tx;
    assign full     = (r_count == CNT_W'(FIFO_DEPTH));
    assign busy     = (r_count != '0) || (r_state != TX_IDLE);
    assign count    = r_count;
    assign overflow = r_ovf;

endmodule

// File: rtl/data_bus_responder.sv
// Data-port responder for the pipelined core: word RAM plus a small I/O block
// (LEDs, UART transmitter, cycle counter, end-of-run flag). Reads are
// combinational; writes commit on the rising clock edge.
module data_bus_responder
    import data_bus_pkg::*;
#(
    parameter int MEM_WORDS  = 1024,
    parameter     INIT_FILE  = "",
    parameter int UART_DIV   = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    output logic [31:0] ReadData,
    output logic        uart_tx,
    output logic [7:0]  leds,
    output logic        endcontrol
);

    localparam int RAM_AW     = $clog2(MEM_WORDS);
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]           r_ram [MEM_WORDS];
    logic [7:0]            r_leds;
    logic [31:0]           r_cycles;
    logic                  r_end;

    logic                  w_io_sel;
    logic [2:0]            w_io_reg;
    logic [RAM_AW-1:0]     w_ram_idx;
    logic                  w_wr_io;
    logic                  w_wr_ram;
    logic                  w_push;
    logic [31:0]           w_io_rdata;

    logic                  w_fifo_full;
    logic                  w_fifo_busy;
    logic                  w_fifo_ovf;
    logic [FIFO_CNT_W-1:0] w_fifo_count;

    // Upper address bits outside the decode are don't-care; RAM aliases through them
    logic                  w_unused_addr;
    assign w_unused_addr = ^Address;

    assign w_io_sel  = Address[IO_SEL_BIT];
    assign w_io_reg  = Address[4:2];
    assign w_ram_idx = Address[RAM_AW+1:2];
    assign w_wr_io   = MemWrite && w_io_sel;
    assign w_wr_ram  = MemWrite && !w_io_sel;
    assign w_push    = w_wr_io && (w_io_reg == IO_UART_DATA);

    // RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (w_wr_ram) r_ram[w_ram_idx] <= WriteData;
    end

    // LED register, free-running cycle counter and sticky end-of-run flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_leds   <= '0;
            r_cycles <= '0;
            r_end    <= 1'b0;
        end else begin
            r_cycles <= r_cycles + 32'd1;
            if (w_wr_io && (w_io_reg == IO_LEDS)) r_leds <= WriteData[7:0];
            if (w_wr_io && (w_io_reg == IO_END))  r_end  <= 1'b1;
        end
    end

    // I/O read mux; unmapped and write-only registers read as zero
    always_comb begin
        w_io_rdata = '0;
        case (w_io_reg)
            IO_LEDS: w_io_rdata = {24'b0, r_leds};
            IO_UART_STATUS: begin
                w_io_rdata[STAT_FULL_BIT]          = w_fifo_full;
                w_io_rdata[STAT_BUSY_BIT]          = w_fifo_busy;
                w_io_rdata[STAT_OVF_BIT]           = w_fifo_ovf;
                w_io_rdata[STAT_COUNT_LSB +: 8]    = 8'(w_fifo_count);
            end
            IO_CYCLES: w_io_rdata = r_cycles;
            IO_END:    w_io_rdata = {31'b0, r_end};
            default:   w_io_rdata = '0;
        endcase
    end

    // Read data reflects pre-write contents during a same-address store
    assign ReadData = w_io_sel ? w_io_rdata : r_ram[w_ram_idx];

    uart_tx_fifo #(
        .UART_DIV   (UART_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_uart (
        .clk      (clk),
        .reset    (reset),
        .push     (w_push),
        .din      (WriteData[7:0]),
        .tx       (uart_tx),
        .full     (w_fifo_full),
        .busy     (w_fifo_busy),
        .count    (w_fifo_count),
        .overflow (w_fifo_ovf)
    );

    assign leds       = r_leds;
    assign endcontrol = r_end;

endmodule
